// File: rtl/tsc_pkg.sv
// Shared TSC CPU definitions: datapath widths, write-back state encoding and
// the MEM->WB instruction bundle used by both the MEM and WB stages.
package tsc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;
    localparam int NUM_W  = 16;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              reg_write;
        logic [ADDR_W-1:0] dest;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic              is_wwd;
        logic [DATA_W-1:0] wwd_data;
        logic              is_halt;
    } mem_wb_t;

    function automatic logic [DATA_W-1:0] wb_select(input mem_wb_t f);
        return f.mem_to_reg ? f.mem_data : f.alu_result;
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// One decode read port's bypass: forwards the value being written back this
// cycle when the read address matches the write address.
module wb_bypass_mux #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] byp_data
);
    import tsc_pkg::*;

    assign byp_data = (wr_en && (rd_addr == wr_addr)) ? wr_data : rf_data;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches one retiring instruction per cycle, drives the
// register-file write port and decode bypass, counts retirements, handles WWD/HLT.
module wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_is_wwd,
    input  logic [DATA_W-1:0] in_wwd_data,
    input  logic              in_is_halt,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2,
    output logic [15:0]       num_inst,
    output logic [DATA_W-1:0] output_port,
    output logic              is_halted
);
    import tsc_pkg::*;

    mem_wb_t in_fields;

    wb_state_e         state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_is_wwd_q, wb_is_wwd_d;
    logic [DATA_W-1:0] wb_wwd_data_q, wb_wwd_data_d;
    logic              wb_is_halt_q, wb_is_halt_d;
    logic [15:0]       num_inst_q, num_inst_d;
    logic [DATA_W-1:0] output_port_q, output_port_d;

    logic capture;
    logic retire;

    assign in_fields = '{
        reg_write:  in_reg_write,
        dest:       in_dest,
        mem_to_reg: in_mem_to_reg,
        alu_result: in_alu_result,
        mem_data:   in_mem_data,
        is_wwd:     in_is_wwd,
        wwd_data:   in_wwd_data,
        is_halt:    in_is_halt
    };

    assign in_ready = (state_q == RUN);
    assign capture  = in_valid && in_ready && !flush;
    // Anything still held in WB once halted is never retired.
    assign retire   = wb_valid_q && (state_q == RUN);

    always_comb begin
        wb_valid_d     = capture;
        wb_reg_write_d = wb_reg_write_q;
        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;
        wb_is_wwd_d    = wb_is_wwd_q;
        wb_wwd_data_d  = wb_wwd_data_q;
        wb_is_halt_d   = wb_is_halt_q;
        num_inst_d     = num_inst_q;
        output_port_d  = output_port_q;
        state_d        = state_q;

        if (capture) begin
            wb_reg_write_d = in_fields.reg_write;
            wb_dest_d      = in_fields.dest;
            wb_data_d      = wb_select(in_fields);
            wb_is_wwd_d    = in_fields.is_wwd;
            wb_wwd_data_d  = in_fields.wwd_data;
            wb_is_halt_d   = in_fields.is_halt;
        end

        if (retire) begin
            num_inst_d = num_inst_q + 16'd1;
            if (wb_is_wwd_q) begin
                output_port_d = wb_wwd_data_q;
            end
            if (wb_is_halt_q) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_dest_q      <= '0;
            wb_data_q      <= '0;
            wb_is_wwd_q    <= 1'b0;
            wb_wwd_data_q  <= '0;
            wb_is_halt_q   <= 1'b0;
            num_inst_q     <= 16'd0;
            output_port_q  <= '0;
        end else begin
            state_q        <= state_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
            wb_is_wwd_q    <= wb_is_wwd_d;
            wb_wwd_data_q  <= wb_wwd_data_d;
            wb_is_halt_q   <= wb_is_halt_d;
            num_inst_q     <= num_inst_d;
            output_port_q  <= output_port_d;
        end
    end

    assign rf_write      = retire && wb_reg_write_q;
    assign rf_write_addr = wb_dest_q;
    assign rf_write_data = wb_data_q;
    assign num_inst      = num_inst_q;
    assign output_port   = output_port_q;
    assign is_halted     = (state_q == HALTED);

    logic [ADDR_W-1:0] rd_addr  [2];
    logic [DATA_W-1:0] rf_data  [2];
    logic [DATA_W-1:0] byp_data [2];

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign rf_data[0] = rf_data1;
    assign rf_data[1] = rf_data2;
    assign byp_data1  = byp_data[0];
    assign byp_data2  = byp_data[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_byp
        wb_bypass_mux #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_byp (
            .wr_en    (rf_write),
            .wr_addr  (wb_dest_q),
            .wr_data  (wb_data_q),
            .rd_addr  (rd_addr[gi]),
            .rf_data  (rf_data[gi]),
            .byp_data (byp_data[gi])
        );
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps plus random traffic against a
// transaction-level model of the write-back stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush;
    logic        in_reg_write, in_mem_to_reg, in_is_wwd, in_is_halt;
    logic [1:0]  in_dest, rd_addr1, rd_addr2, rf_write_addr;
    logic [15:0] in_alu_result, in_mem_data, in_wwd_data;
    logic [15:0] rf_data1, rf_data2, byp_data1, byp_data2;
    logic        rf_write, is_halted;
    logic [15:0] rf_write_data, num_inst, output_port;

    int checks = 0;
    int errors = 0;

    // Model: the instruction sitting in WB plus the architectural counters.
    logic        m_valid, m_rw, m_wwd, m_halt, m_halted;
    logic [1:0]  m_dest;
    logic [15:0] m_data, m_wwdd, m_cnt, m_port;
    logic [15:0] n0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_reg_write(in_reg_write), .in_dest(in_dest), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_is_wwd(in_is_wwd), .in_wwd_data(in_wwd_data), .in_is_halt(in_is_halt),
        .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_wwd = 0; m_halt = 0; m_halted = 0;
        m_dest = 0; m_data = 0; m_wwdd = 0; m_cnt = 0; m_port = 0;
    endtask

    task automatic drive(input logic v, input logic f, input logic rw, input logic [1:0] d,
                         input logic m2r, input logic [15:0] alu, input logic [15:0] mem,
                         input logic wwd, input logic [15:0] wwdd, input logic hlt);
        in_valid = v; flush = f; in_reg_write = rw; in_dest = d; in_mem_to_reg = m2r;
        in_alu_result = alu; in_mem_data = mem; in_is_wwd = wwd; in_wwd_data = wwdd;
        in_is_halt = hlt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'd0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    endtask

    // Starts just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic cycle();
        logic exp_wr;
        logic accept;
        #1;
        exp_wr = m_valid && m_rw && !m_halted;
        check("rf_write", rf_write, exp_wr);
        if (exp_wr) begin
            check("rf_write_addr", rf_write_addr, m_dest);
            check("rf_write_data", rf_write_data, m_data);
        end
        check("in_ready", in_ready, !m_halted);
        check("is_halted", is_halted, m_halted);
        check("num_inst", num_inst, m_cnt);
        check("output_port", output_port, m_port);
        check("byp_data1", byp_data1, (exp_wr && rd_addr1 == m_dest) ? m_data : rf_data1);
        check("byp_data2", byp_data2, (exp_wr && rd_addr2 == m_dest) ? m_data : rf_data2);
        @(posedge clk);
        accept = in_valid && !flush && !m_halted;
        if (m_valid && !m_halted) begin
            m_cnt = m_cnt + 16'd1;
            if (m_wwd) m_port = m_wwdd;
            if (m_halt) m_halted = 1'b1;
        end
        if (accept && !(m_halted && !in_ready)) begin
            m_valid = 1'b1; m_rw = in_reg_write; m_dest = in_dest;
            m_data = in_mem_to_reg ? in_mem_data : in_alu_result;
            m_wwd = in_is_wwd; m_wwdd = in_wwd_data; m_halt = in_is_halt;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic reset_mid_cycle(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_rf_write"}, rf_write, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_is_halted"}, is_halted, 1'b0);
        check({tag, "_num_inst"}, num_inst, 16'h0000);
        check({tag, "_output_port"}, output_port, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        rd_addr1 = 0; rd_addr2 = 0; rf_data1 = 0; rf_data2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        check("reset_rf_write", rf_write, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_is_halted", is_halted, 1'b0);
        check("reset_num_inst", num_inst, 16'h0000);
        check("reset_output_port", output_port, 16'h0000);
        check("reset_addr", rf_write_addr, 2'd0);
        check("reset_data", rf_write_data, 16'h0000);

        // ALU write to r2
        drive(1, 0, 1, 2'd2, 0, 16'h1234, 16'h0000, 0, 16'h0, 0);
        cycle();
        idle();
        check("alu_rf_write", rf_write, 1'b1);
        check("alu_addr", rf_write_addr, 2'd2);
        check("alu_data", rf_write_data, 16'h1234);
        cycle();
        check("alu_num_inst", num_inst, 16'd1);

        // Load selects memory data
        drive(1, 0, 1, 2'd1, 1, 16'h0001, 16'hBEEF, 0, 16'h0, 0);
        cycle();
        idle();
        check("load_data", rf_write_data, 16'hBEEF);
        cycle();

        // Bypass on port 1 only
        drive(1, 0, 1, 2'd3, 0, 16'h00AA, 16'h0000, 0, 16'h0, 0);
        cycle();
        idle();
        rd_addr1 = 2'd3; rf_data1 = 16'h0000; rd_addr2 = 2'd1; rf_data2 = 16'h5555;
        #1;
        check("byp1_hit", byp_data1, 16'h00AA);
        check("byp2_miss", byp_data2, 16'h5555);
        cycle();
        check("count_three", num_inst, 16'd3);

        // Flush beats valid
        drive(1, 1, 1, 2'd0, 0, 16'h4444, 16'h0000, 0, 16'h0, 0);
        cycle();
        idle();
        check("flush_rf_write", rf_write, 1'b0);
        cycle();
        check("flush_num_inst", num_inst, 16'd3);

        // Random traffic without HLT
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom),
                  2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3) == 0, 16'($urandom), 0);
            rd_addr1 = 2'($urandom); rd_addr2 = 2'($urandom);
            rf_data1 = 16'($urandom); rf_data2 = 16'($urandom);
            cycle();
        end

        // WWD then HLT (HLT also writes r0)
        idle();
        cycle();
        n0 = m_cnt;
        drive(1, 0, 0, 2'd0, 0, 16'h0, 16'h0, 1, 16'hCAFE, 0);
        cycle();
        drive(1, 0, 1, 2'd0, 0, 16'h7777, 16'h0, 0, 16'h0, 1);
        cycle();
        idle();
        check("wwd_port", output_port, 16'hCAFE);
        check("hlt_rf_write", rf_write, 1'b1);
        check("hlt_data", rf_write_data, 16'h7777);
        cycle();
        check("hlt_is_halted", is_halted, 1'b1);
        check("hlt_in_ready", in_ready, 1'b0);
        check("hlt_num_inst", num_inst, n0 + 16'd2);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2'(i), 0, 16'h9999, 16'h0, 1, 16'h1111, 0);
            cycle();
            check("halted_rf_write", rf_write, 1'b0);
            check("halted_num_inst", num_inst, n0 + 16'd2);
            check("halted_port", output_port, 16'hCAFE);
        end

        idle();
        reset_mid_cycle("rst_halted");

        // Reset while a write is in WB
        drive(1, 0, 1, 2'd1, 0, 16'h5A5A, 16'h0, 0, 16'h0, 0);
        cycle();
        idle();
        check("pre_rst_rf_write", rf_write, 1'b1);
        reset_mid_cycle("rst_midwrite");
        cycle();

        // Counter wrap: retire 0xFFFF instructions, then one more
        n0 = m_cnt;
        drive(1, 0, 0, 2'd0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
        for (int i = 0; i < 65535 - int'(n0); i++) cycle();
        idle();
        cycle();
        check("count_ffff", num_inst, 16'hFFFF);
        drive(1, 0, 0, 2'd0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
        cycle();
        idle();
        cycle();
        check("count_wrap", num_inst, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
